// File: rtl/bot31_sys_client.sv
// System-side client of the Rojobot register interface: a queue of timed motor commands
// and a coherent snapshot of the BOT state that is latched on every update-flag toggle.
module bot31_sys_client #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TICKW = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       upd_sysregs,
  input  logic [7:0]                 LocX,
  input  logic [7:0]                 LocY,
  input  logic [7:0]                 BotInfo,
  input  logic [7:0]                 Sensors,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_mot,
  input  logic [TICKW-1:0]           cmd_ticks,
  input  logic                       abort,
  output logic [7:0]                 MotCtl,
  output logic                       busy,
  output logic                       cmd_done,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic [7:0]                 snap_LocX,
  output logic [7:0]                 snap_LocY,
  output logic [7:0]                 snap_BotInfo,
  output logic [7:0]                 snap_Sensors,
  output logic                       snap_valid,
  output logic [15:0]                upd_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic               upd_q;
  logic               upd_evt;
  logic [7:0]         mot_q, mot_d;
  logic [TICKW-1:0]   remain_q, remain_d;
  logic               done_d;
  logic               ready_q;

  logic [7:0]         mem_mot   [DEPTH];
  logic [TICKW-1:0]   mem_ticks [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               push, pop;
  logic [7:0]         head_mot;
  logic [TICKW-1:0]   head_ticks;

  assign upd_evt    = upd_sysregs ^ upd_q;
  assign head_mot   = mem_mot[rd_ptr_q];
  // A hold count of zero is treated as a single update.
  assign head_ticks = (mem_ticks[rd_ptr_q] == '0) ? TICKW'(1) : mem_ticks[rd_ptr_q];

  assign push      = cmd_valid & ready_q & ~abort;
  assign cmd_ready = ready_q;
  assign MotCtl    = mot_q;
  assign busy      = (state_q == StRun);
  assign q_count   = count_q;

  // Command sequencer
  always_comb begin
    state_d  = state_q;
    mot_d    = mot_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    if (abort) begin
      state_d = StIdle;
      mot_d   = 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            pop      = 1'b1;
            mot_d    = head_mot;
            remain_d = head_ticks;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (upd_evt) begin
            if (remain_q == TICKW'(1)) begin
              done_d = 1'b1;
              if (count_q != '0) begin
                pop      = 1'b1;
                mot_d    = head_mot;
                remain_d = head_ticks;
              end else begin
                state_d = StIdle;
                mot_d   = 8'h00;
              end
            end else begin
              remain_d = remain_q - TICKW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      mot_q    <= 8'h00;
      remain_q <= '0;
      cmd_done <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mot_q    <= mot_d;
      remain_q <= remain_d;
      cmd_done <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Registered so cmd_ready stays low while in reset.
      ready_q  <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_mot[wr_ptr_q]   <= cmd_mot;
      mem_ticks[wr_ptr_q] <= cmd_ticks;
    end
  end

  // Update detection and snapshot; independent of abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_q        <= 1'b0;
      snap_LocX    <= 8'h00;
      snap_LocY    <= 8'h00;
      snap_BotInfo <= 8'h00;
      snap_Sensors <= 8'h00;
      snap_valid   <= 1'b0;
      upd_cnt      <= 16'h0000;
    end else begin
      upd_q      <= upd_sysregs;
      snap_valid <= upd_evt;
      if (upd_evt) begin
        snap_LocX    <= LocX;
        snap_LocY    <= LocY;
        snap_BotInfo <= BotInfo;
        snap_Sensors <= Sensors;
        upd_cnt      <= upd_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bot31_sys_client.sv
// Directed self-checking bench for bot31_sys_client: command queueing, timing,
// abort, async reset, hold-count boundary and BOT snapshot.
module tb_bot31_sys_client;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        upd_sysregs;
  logic [7:0]  LocX, LocY, BotInfo, Sensors;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_mot;
  logic [7:0]  cmd_ticks;
  logic        abort;
  logic [7:0]  MotCtl;
  logic        busy;
  logic        cmd_done;
  logic [3:0]  q_count;
  logic [7:0]  snap_LocX, snap_LocY, snap_BotInfo, snap_Sensors;
  logic        snap_valid;
  logic [15:0] upd_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bot31_sys_client #(.DEPTH(8), .TICKW(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .upd_sysregs  (upd_sysregs),
    .LocX         (LocX),
    .LocY         (LocY),
    .BotInfo      (BotInfo),
    .Sensors      (Sensors),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mot      (cmd_mot),
    .cmd_ticks    (cmd_ticks),
    .abort        (abort),
    .MotCtl       (MotCtl),
    .busy         (busy),
    .cmd_done     (cmd_done),
    .q_count      (q_count),
    .snap_LocX    (snap_LocX),
    .snap_LocY    (snap_LocY),
    .snap_BotInfo (snap_BotInfo),
    .snap_Sensors (snap_Sensors),
    .snap_valid   (snap_valid),
    .upd_cnt      (upd_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    upd_sysregs = ~upd_sysregs;
    step();
  endtask

  task automatic push(input logic [7:0] mot, input logic [7:0] ticks);
    cmd_valid = 1'b1;
    cmd_mot   = mot;
    cmd_ticks = ticks;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; upd_sysregs = 1'b0; abort = 1'b0;
    LocX = 8'h00; LocY = 8'h00; BotInfo = 8'h00; Sensors = 8'h00;
    cmd_valid = 1'b0; cmd_mot = 8'h00; cmd_ticks = 8'h00;

    // 1: reset state
    #3;
    check("rst_ready_low", {15'd0, cmd_ready}, 16'd0);
    #9 reset_n = 1'b1;
    step();
    check("rst_motctl", {8'd0, MotCtl}, 16'h00);
    check("rst_ready", {15'd0, cmd_ready}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_qcount", {12'd0, q_count}, 16'd0);
    check("rst_snap", {snap_LocX, snap_Sensors}, 16'h0000);

    // 2: single command held for 3 updates
    push(8'hA6, 8'd3);
    check("t2_q1", {12'd0, q_count}, 16'd1);
    check("t2_mot_pre", {8'd0, MotCtl}, 16'h00);
    step();
    check("t2_mot_a6", {8'd0, MotCtl}, 16'hA6);
    check("t2_busy", {15'd0, busy}, 16'd1);
    toggle();
    check("t2_snapv", {15'd0, snap_valid}, 16'd1);
    repeat (10) step();
    toggle();
    repeat (10) step();
    check("t2_mot_hold", {8'd0, MotCtl}, 16'hA6);
    check("t2_done_pre", {15'd0, cmd_done}, 16'd0);
    toggle();
    check("t2_done", {15'd0, cmd_done}, 16'd1);
    check("t2_mot_00", {8'd0, MotCtl}, 16'h00);
    check("t2_idle", {15'd0, busy}, 16'd0);
    step();
    check("t2_done_pulse", {15'd0, cmd_done}, 16'd0);

    // 3: back-to-back commands, no 00 gap
    push(8'h88, 8'd1);
    push(8'h22, 8'd2);
    check("t3_mot_88", {8'd0, MotCtl}, 16'h88);
    check("t3_q1", {12'd0, q_count}, 16'd1);
    toggle();
    check("t3_mot_22", {8'd0, MotCtl}, 16'h22);
    check("t3_done1", {15'd0, cmd_done}, 16'd1);
    check("t3_busy", {15'd0, busy}, 16'd1);
    toggle();
    check("t3_mot_22b", {8'd0, MotCtl}, 16'h22);
    check("t3_nodone", {15'd0, cmd_done}, 16'd0);
    toggle();
    check("t3_mot_00", {8'd0, MotCtl}, 16'h00);
    check("t3_done2", {15'd0, cmd_done}, 16'd1);

    // 4: fill FIFO while a command runs; overflow push ignored
    cmd_valid = 1'b1;
    cmd_ticks = 8'd0;
    for (int i = 0; i < 9; i++) begin
      cmd_mot = 8'h10 + 8'(i);
      step();
    end
    check("t4_full", {12'd0, q_count}, 16'd8);
    check("t4_ready0", {15'd0, cmd_ready}, 16'd0);
    check("t4_mot_10", {8'd0, MotCtl}, 16'h10);
    cmd_mot = 8'h99;
    step();
    cmd_valid = 1'b0;
    check("t4_ovf", {12'd0, q_count}, 16'd8);
    toggle();
    check("t4_mot_11", {8'd0, MotCtl}, 16'h11);
    check("t4_q7", {12'd0, q_count}, 16'd7);
    check("t4_done", {15'd0, cmd_done}, 16'd1);

    // 5: abort with 4 queued and a simultaneous push
    toggle(); toggle(); toggle();
    check("t5_mot_14", {8'd0, MotCtl}, 16'h14);
    check("t5_q4", {12'd0, q_count}, 16'd4);
    abort = 1'b1; cmd_valid = 1'b1; cmd_mot = 8'h5A; cmd_ticks = 8'd2;
    step();
    abort = 1'b0; cmd_valid = 1'b0;
    check("t5_q0", {12'd0, q_count}, 16'd0);
    check("t5_mot_00", {8'd0, MotCtl}, 16'h00);
    check("t5_busy", {15'd0, busy}, 16'd0);
    check("t5_nodone", {15'd0, cmd_done}, 16'd0);
    step();
    check("t5_dropped", {7'd0, busy, MotCtl}, 16'h0000);
    check("t5_q0b", {12'd0, q_count}, 16'd0);

    // 7: maximum hold count of 255 updates
    push(8'hFF, 8'd255);
    step();
    repeat (254) toggle();
    check("t7_hold", {7'd0, busy, MotCtl}, 16'h01FF);
    check("t7_nodone", {15'd0, cmd_done}, 16'd0);
    toggle();
    check("t7_done", {15'd0, cmd_done}, 16'd1);
    check("t7_mot_00", {8'd0, MotCtl}, 16'h00);

    // 8: async reset mid-command clears without an edge
    push(8'h33, 8'd2);
    step();
    check("t8_busy", {15'd0, busy}, 16'd1);
    #2 reset_n = 1'b0; upd_sysregs = 1'b0;
    #1;
    check("t8_rst_mot", {7'd0, busy, MotCtl}, 16'h0000);
    check("t8_rst_cnt", upd_cnt, 16'h0000);
    check("t8_rst_q", {11'd0, cmd_done, q_count}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // 6: coherent snapshot
    LocX = 8'h7C; LocY = 8'h10; BotInfo = 8'h3C; Sensors = 8'hA5;
    step();
    check("t6_novalid", {15'd0, snap_valid}, 16'd0);
    toggle();
    check("t6_snap_xy", {snap_LocX, snap_LocY}, 16'h7C10);
    check("t6_snap_is", {snap_BotInfo, snap_Sensors}, 16'h3CA5);
    check("t6_valid", {15'd0, snap_valid}, 16'd1);
    check("t6_cnt", upd_cnt, 16'd1);
    step();
    check("t6_valid_pulse", {15'd0, snap_valid}, 16'd0);
    LocX = 8'h01;
    step();
    check("t6_snap_hold", {8'd0, snap_LocX}, 16'h7C);
    check("t6_cnt_hold", upd_cnt, 16'd1);
    check("t6_novalid2", {15'd0, snap_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
